// File: rtl/threshold_pkg.sv
// Shared types and the grade->threshold map for the threshold controller.
package threshold_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } key_state_e;

  // Saturating map base + grade*step. 64-bit arithmetic is wider than any
  // THR_W+GRADE_W+1 in use, so the intermediate sum never wraps before the clamp.
  function automatic logic [63:0] grade_to_thr(input logic [63:0] grade,
                                               input logic [63:0] base,
                                               input logic [63:0] step,
                                               input int          thr_w);
    logic [63:0] v;
    logic [63:0] sat;
    v   = base + grade * step;
    sat = (64'd1 << thr_w) - 64'd1;
    return (v > sat) ? sat : v;
  endfunction

endpackage

// File: rtl/threshold_grade_ctrl_key_repeat.sv
// Shared key FSM: one step on press, then auto-repeat while the same key stays
// held on the same channel. Any ambiguity (second key, channel change) parks the
// FSM until both keys are released.
module key_repeat
  import threshold_pkg::*;
#(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000,
  parameter int CH_W       = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_add,
  input  logic            key_sub,
  input  logic [CH_W-1:0] ch_sel,
  output logic            step,
  output logic            dir
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

  key_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            dir_q, dir_nxt;
  logic [CH_W-1:0] ch_q, ch_nxt;

  logic held, abort, one_key, no_key;

  // held/abort are relative to the direction and channel latched at press time
  assign held    = dir_q ? key_add : key_sub;
  assign abort   = (dir_q ? key_sub : key_add) || (ch_sel != ch_q);
  assign one_key = key_add ^ key_sub;
  assign no_key  = !key_add && !key_sub;

  // State, hold counter and press context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir_q <= 1'b0;
      ch_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dir_q <= dir_nxt;
      ch_q  <= ch_nxt;
    end
  end

  // Next state; the counter clears on every transition out of a counting state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    dir_nxt   = dir_q;
    ch_nxt    = ch_q;
    case (state)
      IDLE: begin
        if (one_key) begin
          state_nxt = PRESS;
          dir_nxt   = key_add;
          ch_nxt    = ch_sel;
        end else if (key_add && key_sub) begin
          state_nxt = WAIT_REL;
        end
      end
      PRESS: begin
        if (!held)                  state_nxt = IDLE;
        else if (abort)             state_nxt = WAIT_REL;
        else if (cnt == DLY_LAST)   state_nxt = REPEAT;
        else                        cnt_nxt   = cnt + 1'b1;
      end
      REPEAT: begin
        if (!held)                  state_nxt = IDLE;
        else if (abort)             state_nxt = WAIT_REL;
        else if (cnt != PER_LAST)   cnt_nxt   = cnt + 1'b1;
      end
      default: begin
        if (no_key) state_nxt = IDLE;
      end
    endcase
  end

  // Step pulse; in IDLE the direction comes straight from the key being pressed
  always_comb begin
    step = 1'b0;
    dir  = dir_q;
    case (state)
      IDLE: begin
        step = one_key;
        dir  = key_add;
      end
      PRESS:   step = held && !abort && (cnt == DLY_LAST);
      REPEAT:  step = held && !abort && (cnt == PER_LAST);
      default: step = 1'b0;
    endcase
  end

endmodule

// File: rtl/threshold_grade_ctrl.sv
// Per-channel threshold grades driven by add/sub keys; each grade is mapped to a
// registered threshold, with a pulse whenever any threshold value changes.
module threshold_grade_ctrl
  import threshold_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int GRADE_W    = 4,
  parameter int THR_W      = 8,
  parameter int GRADE_INIT = 6,
  parameter int THR_BASE   = 5,
  parameter int THR_STEP   = 5,
  parameter int WRAP_EN    = 1,
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_add,
  input  logic                    key_sub,
  input  logic [CH_W-1:0]         ch_sel,
  output logic [N_CH*GRADE_W-1:0] grade_bus,
  output logic [N_CH*THR_W-1:0]   thr_bus,
  output logic                    thr_upd,
  output logic                    at_min,
  output logic                    at_max
);

  typedef logic [GRADE_W-1:0] grade_t;
  typedef logic [THR_W-1:0]   thr_t;

  localparam grade_t G_MAX    = '1;
  localparam grade_t G_INIT   = grade_t'(GRADE_INIT);
  localparam thr_t   THR_INIT = thr_t'(grade_to_thr(64'(GRADE_INIT), 64'(THR_BASE),
                                                    64'(THR_STEP), THR_W));

  logic step, dir;

  logic [N_CH-1:0][GRADE_W-1:0] grade_q, grade_stepped;
  logic [N_CH-1:0][THR_W-1:0]   thr_q, thr_map;
  grade_t                       sel_grade;
  logic                         sel_valid;

  key_repeat #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER),
    .CH_W      (CH_W)
  ) u_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_add(key_add),
    .key_sub(key_sub),
    .ch_sel (ch_sel),
    .step   (step),
    .dir    (dir)
  );

  // Candidate next grade per channel: wrap or saturate at both ends
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      if (dir)
        grade_stepped[c] = (grade_q[c] == G_MAX) ? ((WRAP_EN != 0) ? '0 : G_MAX)
                                                 : grade_q[c] + 1'b1;
      else
        grade_stepped[c] = (grade_q[c] == '0) ? ((WRAP_EN != 0) ? G_MAX : '0)
                                              : grade_q[c] - 1'b1;
    end
  end

  // Grade registers; out-of-range ch_sel matches no channel, so no step lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grade_q <= {N_CH{G_INIT}};
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (step && (ch_sel == CH_W'(c))) grade_q[c] <= grade_stepped[c];
    end
  end

  // Grade -> threshold map for every channel
  always_comb begin
    for (int c = 0; c < N_CH; c++)
      thr_map[c] = thr_t'(grade_to_thr(64'(grade_q[c]), 64'(THR_BASE),
                                       64'(THR_STEP), THR_W));
  end

  // Threshold registers; thr_upd rises with the cycle the new value appears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q   <= {N_CH{THR_INIT}};
      thr_upd <= 1'b0;
    end else begin
      thr_q   <= thr_map;
      thr_upd <= (thr_map != thr_q);
    end
  end

  // Selected-channel grade for the end-of-range flags
  always_comb begin
    sel_grade = '0;
    sel_valid = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == CH_W'(c)) begin
        sel_grade = grade_q[c];
        sel_valid = 1'b1;
      end
    end
  end

  assign at_min    = sel_valid && (sel_grade == '0);
  assign at_max    = sel_valid && (sel_grade == G_MAX);
  assign grade_bus = grade_q;
  assign thr_bus   = thr_q;

endmodule

// File: tb/tb_threshold_grade_ctrl.sv
// Bench for threshold_grade_ctrl: three instances (wrap, saturate, steep map)
// share one key stimulus; a press-schedule model checks every cycle.
module tb_threshold_grade_ctrl;

  localparam int ND  = 3;
  localparam int NC  = 2;
  localparam int DLY = 20;
  localparam int PER = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_add = 1'b0;
  logic       key_sub = 1'b0;
  logic [0:0] ch_sel = 1'b0;

  logic [ND-1:0][7:0]  gb;
  logic [ND-1:0][15:0] tbus;
  logic [ND-1:0]       upd, amin, amax;

  always #5 clk = ~clk;

  threshold_grade_ctrl #(.N_CH(2), .GRADE_W(4), .THR_W(8), .GRADE_INIT(6), .THR_BASE(5),
    .THR_STEP(5), .WRAP_EN(1), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_add(key_add), .key_sub(key_sub), .ch_sel(ch_sel),
    .grade_bus(gb[0]), .thr_bus(tbus[0]), .thr_upd(upd[0]), .at_min(amin[0]), .at_max(amax[0]));

  threshold_grade_ctrl #(.N_CH(2), .GRADE_W(4), .THR_W(8), .GRADE_INIT(6), .THR_BASE(5),
    .THR_STEP(5), .WRAP_EN(0), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_add(key_add), .key_sub(key_sub), .ch_sel(ch_sel),
    .grade_bus(gb[1]), .thr_bus(tbus[1]), .thr_upd(upd[1]), .at_min(amin[1]), .at_max(amax[1]));

  threshold_grade_ctrl #(.N_CH(2), .GRADE_W(4), .THR_W(8), .GRADE_INIT(6), .THR_BASE(5),
    .THR_STEP(20), .WRAP_EN(1), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut2 (
    .clk(clk), .rst_n(rst_n), .key_add(key_add), .key_sub(key_sub), .ch_sel(ch_sel),
    .grade_bus(gb[2]), .thr_bus(tbus[2]), .thr_upd(upd[2]), .at_min(amin[2]), .at_max(amax[2]));

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int wrap_m[ND] = '{1, 0, 1};
  int stp_m[ND]  = '{5, 5, 20};
  int g[ND][NC];
  int t[ND][NC];
  bit u[ND];
  bit holding, blocked, mdir;
  int mch, h;

  function automatic int map_thr(input int gr, input int st);
    int v;
    v = 5 + gr * st;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        g[d][c] = 6;
        t[d][c] = map_thr(6, stp_m[d]);
      end
      u[d] = 1'b0;
    end
    holding = 1'b0;
    blocked = 1'b0;
    h = 0;
  endtask

  // One clock edge: decide from the press schedule whether a step lands, then
  // advance thresholds (from old grades) and grades.
  task automatic model_cycle();
    bit st, held, other;
    int nt;
    st = 1'b0;
    if (blocked) begin
      if (!key_add && !key_sub) blocked = 1'b0;
    end else if (!holding) begin
      if (key_add ^ key_sub) begin
        st = 1'b1; holding = 1'b1; mdir = key_add; mch = int'(ch_sel); h = 0;
      end else if (key_add && key_sub) begin
        blocked = 1'b1;
      end
    end else begin
      held  = mdir ? key_add : key_sub;
      other = mdir ? key_sub : key_add;
      if (!held) holding = 1'b0;
      else if (other || int'(ch_sel) != mch) begin
        holding = 1'b0; blocked = 1'b1;
      end else begin
        h++;
        if (h == DLY || (h > DLY && (h - DLY) % PER == 0)) st = 1'b1;
      end
    end
    for (int d = 0; d < ND; d++) begin
      u[d] = 1'b0;
      for (int c = 0; c < NC; c++) begin
        nt = map_thr(g[d][c], stp_m[d]);
        if (nt != t[d][c]) u[d] = 1'b1;
        t[d][c] = nt;
      end
      if (st) begin
        if (mdir) g[d][mch] = (g[d][mch] == 15) ? (wrap_m[d] != 0 ? 0 : 15) : g[d][mch] + 1;
        else      g[d][mch] = (g[d][mch] == 0)  ? (wrap_m[d] != 0 ? 15 : 0) : g[d][mch] - 1;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0]  eg;
    logic [15:0] et;
    int sg;
    for (int d = 0; d < ND; d++) begin
      eg = {4'(g[d][1]), 4'(g[d][0])};
      et = {8'(t[d][1]), 8'(t[d][0])};
      sg = g[d][int'(ch_sel)];
      chk($sformatf("grade_bus dut%0d", d), 32'(gb[d]), 32'(eg));
      chk($sformatf("thr_bus dut%0d", d), 32'(tbus[d]), 32'(et));
      chk($sformatf("thr_upd dut%0d", d), 32'(upd[d]), 32'(u[d]));
      chk($sformatf("at_min/at_max dut%0d", d), 32'({amin[d], amax[d]}),
          32'({sg == 0, sg == 15}));
    end
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit a, input bit s, input bit ch);
    key_add = a;
    key_sub = s;
    ch_sel  = ch;
  endtask

  typedef struct {
    bit         a;
    bit         s;
    bit         ch;
    int         n;
    logic [7:0]  g0;
    logic [15:0] t0;
    logic [7:0]  g1;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // {add, sub, ch, cycles, dut0 grade_bus, dut0 thr_bus, dut1 grade_bus}
    tbl[0]  = '{1'b1, 1'b0, 1'b0,  3, 8'h67, 16'h2328, 8'h67};  // single press
    tbl[1]  = '{1'b0, 1'b0, 1'b0,  3, 8'h67, 16'h2328, 8'h67};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 40, 8'h6c, 16'h2341, 8'h6c};  // 5 steps with repeat
    tbl[3]  = '{1'b0, 1'b0, 1'b0,  3, 8'h6c, 16'h2341, 8'h6c};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 40, 8'h1c, 16'h0a41, 8'h1c};  // ch1 down 5
    tbl[5]  = '{1'b0, 1'b0, 1'b1,  3, 8'h1c, 16'h0a41, 8'h1c};
    tbl[6]  = '{1'b0, 1'b1, 1'b1,  3, 8'h0c, 16'h0541, 8'h0c};  // ch1 -> 0
    tbl[7]  = '{1'b0, 1'b0, 1'b1,  3, 8'h0c, 16'h0541, 8'h0c};
    tbl[8]  = '{1'b0, 1'b1, 1'b1,  3, 8'hfc, 16'h5041, 8'h0c};  // sub at 0: wrap / hold
    tbl[9]  = '{1'b0, 1'b0, 1'b1,  3, 8'hfc, 16'h5041, 8'h0c};
    tbl[10] = '{1'b1, 1'b0, 1'b1,  3, 8'h0c, 16'h0541, 8'h1c};  // add at max wraps
    tbl[11] = '{1'b0, 1'b0, 1'b1,  3, 8'h0c, 16'h0541, 8'h1c};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 30, 8'h0c, 16'h0541, 8'h1c};  // both keys: no step
    tbl[13] = '{1'b0, 1'b0, 1'b0,  3, 8'h0c, 16'h0541, 8'h1c};

    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset grade_bus", 32'(gb[0]), 32'h66);
    chk("reset thr_bus", 32'(tbus[0]), 32'h2323);
    chk("reset thr_bus steep", 32'(tbus[2]), 32'h7d7d);
    chk("reset thr_upd", 32'(upd), 32'h0);
    check_all();
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].a, tbl[i].s, tbl[i].ch);
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d grade dut0", i), 32'(gb[0]), 32'(tbl[i].g0));
      chk($sformatf("vec%0d thr dut0", i), 32'(tbus[0]), 32'(tbl[i].t0));
      chk($sformatf("vec%0d grade dut1", i), 32'(gb[1]), 32'(tbl[i].g1));
    end

    // channel change mid-repeat, then a second key, both park until full release
    drive(1'b1, 1'b0, 1'b0);
    repeat (22) tick();
    chk("pre-toggle grade", 32'(gb[0]), 32'h0e);
    drive(1'b1, 1'b0, 1'b1);
    repeat (20) tick();
    drive(1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    drive(1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    drive(1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    chk("abort holds grade dut0", 32'(gb[0]), 32'h0e);
    chk("abort holds grade dut1", 32'(gb[1]), 32'h1e);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    drive(1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    chk("press after release", 32'(gb[0]), 32'h1e);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // climb to 15, then step past the top: wrap vs saturate vs clamped map
    rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    repeat (58) tick();
    chk("top grade dut1", 32'(gb[1]), 32'h6f);
    chk("top thr dut0", 32'(tbus[0]), 32'h2350);
    chk("saturated thr dut2", 32'(tbus[2]), 32'h7dff);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("wrap grade dut0", 32'(gb[0]), 32'h60);
    chk("wrap thr dut0", 32'(tbus[0]), 32'h2305);
    chk("hold grade dut1", 32'(gb[1]), 32'h6f);
    chk("hold thr dut1", 32'(tbus[1]), 32'h2350);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // reset in the middle of an auto-repeat hold, key still down across it
    drive(1'b1, 1'b0, 1'b0);
    repeat (30) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    repeat (22) tick();
    chk("post-reset press+repeat dut0", 32'(gb[0]), 32'h68);
    chk("post-reset press+repeat dut2", 32'(gb[2]), 32'h68);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // random key phases against the model
    for (int p = 0; p < 60; p++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 40)) tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
